// File: rtl/prog_loader_if.sv
// Program stream (valid/ready) plus RAM write port and run enable between the loader and its neighbours.
// The master modport is the loader side; the slave modport is the stream source / load-store unit side.
interface prog_loader_if #(
    parameter int ADDR_W = 9
);
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [31:0]       wdata;
    logic              working;

    modport master (
        input  in_valid, in_data, in_last,
        output in_ready, addr, wr, wdata, working
    );

    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready, addr, wr, wdata, working
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: streams program words into consecutive RAM addresses, waits a settle delay, then enables execution.
// Optional define LOADER_CHECKSUM_EN: the final beat carries the 32-bit sum of the data words instead of data.
module prog_loader #(
    parameter int ADDR_W    = 9,
    parameter int DEPTH     = 512,
    parameter int BASE_ADDR = 0,
    parameter int RUN_DELAY = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            halt,
    prog_loader_if.master   bus,
    output logic            error,
    output logic [ADDR_W:0] words_loaded
);
    localparam int                DATA_W    = 32;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   WL_MAX    = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]        DLY_END   = 4'(RUN_DELAY);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, ERR} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [3:0]          dly_cnt;
    logic                wr_beat;
    logic                load_start;
    logic                set_err;

    logic                vld_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [DATA_W-1:0]   data_p1;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   csum;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // halt always outranks start and any beat presented in the same cycle
    always_comb begin
        state_nxt  = state;
        wr_beat    = 1'b0;
        load_start = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !halt) begin
                    state_nxt  = LOAD;
                    load_start = 1'b1;
                end
            end
            LOAD: begin
                if (halt) begin
                    state_nxt = IDLE;
                end else if (bus.in_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    if (bus.in_last) begin
                        if (bus.in_data == csum) begin
                            state_nxt = DRAIN;
                        end else begin
                            state_nxt = ERR;
                            set_err   = 1'b1;
                        end
                    end else begin
                        wr_beat = 1'b1;
                        if (ptr == LAST_ADDR) begin
                            state_nxt = ERR;
                            set_err   = 1'b1;
                        end
                    end
`else
                    wr_beat = 1'b1;
                    if (bus.in_last) begin
                        state_nxt = DRAIN;
                    end else if (ptr == LAST_ADDR) begin
                        state_nxt = ERR;
                        set_err   = 1'b1;
                    end
`endif
                end
            end
            DRAIN: begin
                if (halt)                  state_nxt = IDLE;
                else if (dly_cnt == DLY_END) state_nxt = RUN;
            end
            RUN: begin
                if (halt) state_nxt = IDLE;
            end
            ERR: begin
                if (halt) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt  = LOAD;
                    load_start = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0 -> p1: accepted beat becomes a one-cycle write strobe with its address and data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1       <= 1'b0;
            addr_p1      <= '0;
            data_p1      <= '0;
            ptr          <= '0;
            words_loaded <= '0;
            error        <= 1'b0;
            dly_cnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            vld_p1 <= wr_beat;
            if (wr_beat) begin
                addr_p1 <= ptr;
                data_p1 <= bus.in_data;
                if (ptr != LAST_ADDR)       ptr <= ptr + 1'b1;
                if (words_loaded != WL_MAX) words_loaded <= words_loaded + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                csum <= csum + bus.in_data;
`endif
            end
            if (load_start) begin
                ptr          <= FIRST_ADDR;
                words_loaded <= '0;
                error        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                csum         <= '0;
`endif
            end
            if (set_err) error <= 1'b1;
            dly_cnt <= (state == DRAIN) ? dly_cnt + 1'b1 : 4'd0;
        end
    end

    assign bus.in_ready = (state == LOAD);
    assign bus.working  = (state == RUN);
    assign bus.wr       = vld_p1;
    assign bus.addr     = addr_p1;
    assign bus.wdata    = data_p1;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default instance plus a DEPTH=4 instance for the overflow case.
module tb_prog_loader;
    localparam int ADDR_W = 9;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0, halt = 1'b0;
    logic            start4 = 1'b0, halt4 = 1'b0;
    logic            error, error4;
    logic [ADDR_W:0] words_loaded, words_loaded4;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int wr_cnt4 = 0;
    int base;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus();
    prog_loader_if #(.ADDR_W(ADDR_W)) bus4();

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(512), .BASE_ADDR(0), .RUN_DELAY(2)) dut (
        .clock(clock), .reset(reset), .start(start), .halt(halt),
        .bus(bus), .error(error), .words_loaded(words_loaded)
    );

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(4), .BASE_ADDR(0), .RUN_DELAY(2)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .halt(halt4),
        .bus(bus4), .error(error4), .words_loaded(words_loaded4)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.wr === 1'b1)  wr_cnt++;
        if (bus4.wr === 1'b1) wr_cnt4++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // inputs change and outputs are sampled just after the falling edge
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_halt();
        halt = 1'b1; step(); halt = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
        step();
    endtask

    initial begin
        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.in_last = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_last = 1'b0;

        // reset state
        repeat (3) step();
        check("rst_addr", bus.addr, 0);
        check("rst_wr", bus.wr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_working", bus.working, 0);
        check("rst_error", error, 0);
        check("rst_words", words_loaded, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_in_ready4", bus4.in_ready, 0);
        reset = 1'b1;
        step();

        // basic load of three words, last on 0x33
        pulse_start();
        check("t1_in_ready", bus.in_ready, 1);
        base = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            beat(32'h11 * (i + 1), i == 2);
            check("t1_wr", bus.wr, 1);
            check("t1_addr", bus.addr, i);
            check("t1_wdata", bus.wdata, 32'h11 * (i + 1));
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        check("t1_words", words_loaded, 3);
        check("t1_wr_count", wr_cnt - base, 3);
        step();
        check("t1_work_d1", bus.working, 0);
        check("t1_wr_d1", bus.wr, 0);
        step();
        check("t1_work_d2", bus.working, 0);
        step();
        check("t1_work_d3", bus.working, 1);
        check("t1_ready_run", bus.in_ready, 0);

        // halt in RUN, then start+halt together in IDLE, then reload
        pulse_start();
        check("t4_start_ignored", bus.working, 1);
        pulse_halt();
        check("t4_work_off", bus.working, 0);
        check("t4_idle_ready", bus.in_ready, 0);
        start = 1'b1; halt = 1'b1; step(); start = 1'b0; halt = 1'b0;
        check("t4_halt_wins", bus.in_ready, 0);
        pulse_start();
        check("t4_reload_ready", bus.in_ready, 1);
        check("t4_reload_words", words_loaded, 0);

        // gaps: valid 1,0,0,1 across two words
        base = wr_cnt;
        beat(32'hA0, 1'b0);
        check("t2_wr0", bus.wr, 1);
        check("t2_addr0", bus.addr, 0);
        check("t2_wdata0", bus.wdata, 32'hA0);
        bus.in_valid = 1'b0;
        step();
        check("t2_gap1", bus.wr, 0);
        step();
        check("t2_gap2", bus.wr, 0);
        check("t2_hold_addr", bus.addr, 0);
        beat(32'hB0, 1'b1);
        check("t2_wr1", bus.wr, 1);
        check("t2_addr1", bus.addr, 1);
        check("t2_wdata1", bus.wdata, 32'hB0);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        check("t2_wr_count", wr_cnt - base, 2);
        check("t2_words", words_loaded, 2);
        repeat (4) step();
        check("t2_run", bus.working, 1);
        pulse_halt();

        // asynchronous reset between edges while a write strobe is live
        pulse_start();
        bus.in_valid = 1'b1; bus.in_data = 32'h55; bus.in_last = 1'b0;
        @(posedge clock);
        #2;
        check("t5_pre_wr", bus.wr, 1);
        reset = 1'b0;
        #1;
        check("t5_wr", bus.wr, 0);
        check("t5_addr", bus.addr, 0);
        check("t5_wdata", bus.wdata, 0);
        check("t5_ready", bus.in_ready, 0);
        check("t5_words", words_loaded, 0);
        check("t5_working", bus.working, 0);
        bus.in_valid = 1'b0;
        step();
        reset = 1'b1;
        base = wr_cnt;
        repeat (4) step();
        check("t5_no_wr", wr_cnt - base, 0);
        check("t5_idle", bus.in_ready, 0);

        // checksum stimulus: 1,2 then last 3 (good sum) and last 4 (bad sum)
        pulse_start();
        base = wr_cnt;
        beat(32'h1, 1'b0);
        beat(32'h2, 1'b0);
        beat(32'h3, 1'b1);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        repeat (5) step();
`ifdef LOADER_CHECKSUM_EN
        check("t6a_wr_count", wr_cnt - base, 2);
        check("t6a_words", words_loaded, 2);
`else
        check("t6a_wr_count", wr_cnt - base, 3);
        check("t6a_words", words_loaded, 3);
`endif
        check("t6a_run", bus.working, 1);
        check("t6a_error", error, 0);
        pulse_halt();
        pulse_start();
        base = wr_cnt;
        beat(32'h1, 1'b0);
        beat(32'h2, 1'b0);
        beat(32'h4, 1'b1);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        repeat (5) step();
`ifdef LOADER_CHECKSUM_EN
        check("t6b_wr_count", wr_cnt - base, 2);
        check("t6b_error", error, 1);
        check("t6b_run", bus.working, 0);
`else
        check("t6b_wr_count", wr_cnt - base, 3);
        check("t6b_error", error, 0);
        check("t6b_run", bus.working, 1);
`endif
        pulse_halt();

        // overflow on the DEPTH=4 instance: five beats, none last
        start4 = 1'b1; step(); start4 = 1'b0;
        base = wr_cnt4;
        for (int i = 0; i < 5; i++) begin
            bus4.in_valid = 1'b1; bus4.in_data = 32'h100 + i; bus4.in_last = 1'b0;
            step();
            if (i < 4) begin
                check("t3_wr", bus4.wr, 1);
                check("t3_addr", bus4.addr, i);
                check("t3_wdata", bus4.wdata, 32'h100 + i);
            end else begin
                check("t3_no_5th", bus4.wr, 0);
            end
            if (i == 3) check("t3_ready_off", bus4.in_ready, 0);
        end
        bus4.in_valid = 1'b0;
        check("t3_wr_count", wr_cnt4 - base, 4);
        check("t3_error", error4, 1);
        check("t3_working", bus4.working, 0);
        check("t3_words", words_loaded4, 4);
        check("t3_addr_hold", bus4.addr, 3);
        halt4 = 1'b1; step(); halt4 = 1'b0;
        check("t3_err_sticky", error4, 1);
        check("t3_idle_ready", bus4.in_ready, 0);
        start4 = 1'b1; step(); start4 = 1'b0;
        check("t3_err_clear", error4, 0);
        check("t3_reload_ready", bus4.in_ready, 1);
        check("t3_reload_words", words_loaded4, 0);
        halt4 = 1'b1; step(); halt4 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
